// File: rtl/vector_multiply_sequencer.sv
// Steps one vector multiply instruction beat by beat: VRF read, external multiply unit, VRF write-back.
// Optional macro VMUL_SCALAR_EN adds a scalar vs1 operand that replaces the vs1 register read.
module vector_multiply_sequencer #(
    parameter int DATA_WIDTH     = 64,
    parameter int VL_WIDTH       = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [1:0]                issue_operation,
    input  logic [1:0]                issue_sew,
    input  logic [VL_WIDTH-1:0]       issue_vl,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vs2,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vs1,
    input  logic [REG_ADDR_WIDTH-1:0] issue_vd,
    output logic                      vrf_read_enable,
    output logic [REG_ADDR_WIDTH-1:0] vrf_read_addr_a,
    output logic [REG_ADDR_WIDTH-1:0] vrf_read_addr_b,
    input  logic [DATA_WIDTH-1:0]     vrf_read_data_a,
    input  logic [DATA_WIDTH-1:0]     vrf_read_data_b,
    output logic [1:0]                mul_operation,
    output logic [1:0]                mul_sew,
    output logic [DATA_WIDTH-1:0]     mul_vs2,
    output logic [DATA_WIDTH-1:0]     mul_vs1,
    input  logic [DATA_WIDTH-1:0]     mul_vd,
    output logic                      vrf_write_valid,
    input  logic                      vrf_write_ready,
    output logic [REG_ADDR_WIDTH-1:0] vrf_write_addr,
    output logic [DATA_WIDTH-1:0]     vrf_write_data,
    output logic [7:0]                vrf_write_strobe,
    output logic                      done,
`ifdef VMUL_SCALAR_EN
    input  logic                      scalar_valid,
    input  logic [DATA_WIDTH-1:0]     scalar_operand,
`endif
    output logic [2:0]                debug_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // once raised, valid and its payload stay stable until that transfer completes.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        EXEC    = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q, sew_q;
    logic [VL_WIDTH-1:0]       elements_left_q, beat_q, epb;
    logic [REG_ADDR_WIDTH-1:0] vs2_q, vs1_q, vd_q, beat_addr;
    logic [DATA_WIDTH-1:0]     mul_vs2_q, mul_vs1_q, result_q, vs1_operand;
    logic [3:0]                tail_bytes;
    logic [7:0]                tail_strobe;
    logic                      last_beat;

    assign epb       = VL_WIDTH'(4'd8 >> sew_q);
    assign last_beat = elements_left_q <= epb;
    assign beat_addr = beat_q[REG_ADDR_WIDTH-1:0];

    // Only the final partial beat has fewer than EPB elements left, so 3 bits suffice here.
    assign tail_bytes  = {1'b0, elements_left_q[2:0]} << sew_q;
    assign tail_strobe = 8'hFF >> (4'd8 - tail_bytes);

`ifdef VMUL_SCALAR_EN
    logic                  scalar_valid_q;
    logic [DATA_WIDTH-1:0] scalar_q, scalar_splat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scalar_valid_q <= 1'b0;
            scalar_q       <= '0;
        end else if (state_q == IDLE && issue_valid) begin
            scalar_valid_q <= scalar_valid;
            scalar_q       <= scalar_operand;
        end
    end

    always_comb begin
        scalar_splat = scalar_q;
        case (sew_q)
            2'b00:   scalar_splat = {8{scalar_q[7:0]}};
            2'b01:   scalar_splat = {4{scalar_q[15:0]}};
            2'b10:   scalar_splat = {2{scalar_q[31:0]}};
            default: scalar_splat = scalar_q;
        endcase
    end

    assign vs1_operand = scalar_valid_q ? scalar_splat : vrf_read_data_b;
`else
    assign vs1_operand = vrf_read_data_b;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        issue_ready     = 1'b0;
        vrf_read_enable = 1'b0;
        vrf_write_valid = 1'b0;
        done            = 1'b0;
        case (state_q)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) state_d = (issue_vl == '0) ? DONE : READ;
            end
            READ: begin
                vrf_read_enable = 1'b1;
                state_d         = EXEC;
            end
            EXEC:    state_d = CAPTURE;
            CAPTURE: state_d = WRITE;
            WRITE: begin
                vrf_write_valid = 1'b1;
                if (vrf_write_ready) state_d = last_beat ? DONE : READ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q            <= '0;
            sew_q           <= '0;
            elements_left_q <= '0;
            beat_q          <= '0;
            vs2_q           <= '0;
            vs1_q           <= '0;
            vd_q            <= '0;
            mul_vs2_q       <= '0;
            mul_vs1_q       <= '0;
            result_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (issue_valid) begin
                    op_q            <= issue_operation;
                    sew_q           <= issue_sew;
                    elements_left_q <= issue_vl;
                    beat_q          <= '0;
                    vs2_q           <= issue_vs2;
                    vs1_q           <= issue_vs1;
                    vd_q            <= issue_vd;
                end
                EXEC: begin
                    mul_vs2_q <= vrf_read_data_a;
                    mul_vs1_q <= vs1_operand;
                end
                CAPTURE: result_q <= mul_vd;
                WRITE: if (vrf_write_ready) begin
                    beat_q          <= beat_q + VL_WIDTH'(1);
                    elements_left_q <= last_beat ? '0 : elements_left_q - epb;
                end
                default: ;
            endcase
        end
    end

    // Register indices wrap naturally through the REG_ADDR_WIDTH-bit adders.
    assign vrf_read_addr_a  = vrf_read_enable ? vs2_q + beat_addr : '0;
    assign vrf_read_addr_b  = vrf_read_enable ? vs1_q + beat_addr : '0;
    assign vrf_write_addr   = vrf_write_valid ? vd_q + beat_addr : '0;
    assign vrf_write_data   = vrf_write_valid ? result_q : '0;
    assign vrf_write_strobe = !vrf_write_valid ? 8'h00 :
                              (elements_left_q >= epb) ? 8'hFF : tail_strobe;

    assign mul_operation = op_q;
    assign mul_sew       = sew_q;
    assign mul_vs2       = mul_vs2_q;
    assign mul_vs1       = mul_vs1_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_vector_multiply_sequencer.sv
// Directed bench for vector_multiply_sequencer: read-only VRF model, behavioural multiply unit,
// write-beat scoreboard with stall-stability checks, latency and reset checks.
module tb_vector_multiply_sequencer;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_operation;
  logic [1:0]  issue_sew;
  logic [7:0]  issue_vl;
  logic [4:0]  issue_vs2, issue_vs1, issue_vd;
  logic        vrf_read_enable;
  logic [4:0]  vrf_read_addr_a, vrf_read_addr_b;
  logic [63:0] vrf_read_data_a, vrf_read_data_b;
  logic [1:0]  mul_operation, mul_sew;
  logic [63:0] mul_vs2, mul_vs1, mul_vd;
  logic        vrf_write_valid;
  logic        vrf_write_ready;
  logic [4:0]  vrf_write_addr;
  logic [63:0] vrf_write_data;
  logic [7:0]  vrf_write_strobe;
  logic        done;
  logic        sc_valid;
  logic [63:0] sc_operand;
  logic [2:0]  debug_state;

  logic [63:0] mem [32];
  logic [76:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int stall_left = 0;

  vector_multiply_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_operation (issue_operation),
    .issue_sew       (issue_sew),
    .issue_vl        (issue_vl),
    .issue_vs2       (issue_vs2),
    .issue_vs1       (issue_vs1),
    .issue_vd        (issue_vd),
    .vrf_read_enable (vrf_read_enable),
    .vrf_read_addr_a (vrf_read_addr_a),
    .vrf_read_addr_b (vrf_read_addr_b),
    .vrf_read_data_a (vrf_read_data_a),
    .vrf_read_data_b (vrf_read_data_b),
    .mul_operation   (mul_operation),
    .mul_sew         (mul_sew),
    .mul_vs2         (mul_vs2),
    .mul_vs1         (mul_vs1),
    .mul_vd          (mul_vd),
    .vrf_write_valid (vrf_write_valid),
    .vrf_write_ready (vrf_write_ready),
    .vrf_write_addr  (vrf_write_addr),
    .vrf_write_data  (vrf_write_data),
    .vrf_write_strobe(vrf_write_strobe),
    .done            (done),
`ifdef VMUL_SCALAR_EN
    .scalar_valid    (sc_valid),
    .scalar_operand  (sc_operand),
`endif
    .debug_state     (debug_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // VRF: read data returns one cycle after the request
  always @(posedge clock) begin
    if (vrf_read_enable) begin
      vrf_read_data_a <= mem[vrf_read_addr_a];
      vrf_read_data_b <= mem[vrf_read_addr_b];
    end
  end

  // Write sink: holds ready low for stall_left cycles of an offered beat
  always @(posedge clock) begin
    #1;
    if (vrf_write_valid && stall_left > 0) begin
      vrf_write_ready = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      vrf_write_ready = 1'b1;
    end
  end

  function automatic logic [63:0] mul_model(input logic [1:0] op, input logic [1:0] sew,
                                            input logic [63:0] a, input logic [63:0] b);
    int w, n;
    logic [63:0] r, mask, ua, ub, lane;
    logic signed [129:0] ea, eb, p;
    w = 8 << sew;
    n = 8 >> sew;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
    r = '0;
    for (int e = 0; e < n; e++) begin
      ua = (a >> (e * w)) & mask;
      ub = (b >> (e * w)) & mask;
      ea = $signed({66'b0, ua});
      eb = $signed({66'b0, ub});
      if (op != 2'b10 && ua[w-1]) ea = ea - (130'sd1 <<< w);
      if (op[1] == 1'b0 && ub[w-1]) eb = eb - (130'sd1 <<< w);
      p = ea * eb;
      lane = (op == 2'b00) ? p[63:0] : 64'(p >>> w);
      r = r | ((lane & mask) << (e * w));
    end
    return r;
  endfunction

  assign mul_vd = mul_model(mul_operation, mul_sew, mul_vs2, mul_vs1);

  // scoreboard monitor
  logic        held = 1'b0;
  logic [76:0] held_val;
  logic [76:0] got, want;

  always @(negedge clock) begin
    got = {vrf_write_addr, vrf_write_strobe, vrf_write_data};
    if (vrf_read_enable) rd_seen++;
    if (done) done_seen++;
    if (held) begin
      total++;
      if (got !== held_val) begin
        bad++;
        $display("FAIL stall_hold got=%h want=%h", got, held_val);
      end
    end
    held = 1'b0;
    if (vrf_write_valid && vrf_write_ready) begin
      wr_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_beat unexpected got=%h want=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL write_beat got=%h want=%h (addr,strobe,data)", got, want);
        end
      end
    end else if (vrf_write_valid) begin
      held = 1'b1;
      held_val = got;
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [7:0] s, input logic [63:0] d);
    exp_q.push_back({a, s, d});
  endtask

  task automatic issue_only(input logic [1:0] op, input logic [1:0] sew, input logic [7:0] vl,
                            input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
    @(negedge clock);
    check("issue_ready_idle", 64'(issue_ready), 64'd1);
    issue_valid = 1'b1;
    issue_operation = op;
    issue_sew = sew;
    issue_vl = vl;
    issue_vs2 = s2;
    issue_vs1 = s1;
    issue_vd = d;
    @(negedge clock);
    issue_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=none want=%0d", name, exp_lat);
    end else begin
      check(name, 64'(cyc - t0 + 1), 64'(exp_lat));
    end
    @(negedge clock);
  endtask

  initial begin
    int r0, w0, d0;
    reset_n = 1'b0;
    issue_valid = 1'b0;
    issue_operation = '0;
    issue_sew = '0;
    issue_vl = '0;
    issue_vs2 = '0;
    issue_vs1 = '0;
    issue_vd = '0;
    vrf_write_ready = 1'b1;
    vrf_read_data_a = '0;
    vrf_read_data_b = '0;
    sc_valid = 1'b0;
    sc_operand = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[4]  = 64'd3;                    mem[8]  = 64'd5;
    mem[5]  = 64'h0000_0001_0000_0000;  mem[9]  = 64'h0000_0001_0000_0003;
    mem[16] = 64'h7F80_10FF_40C0_0102;  mem[20] = 64'h0202_10FF_0404_7F80;
    mem[17] = 64'h0000_0000_0085_7FF6;  mem[21] = 64'h0000_0000_0003_7F0A;
    mem[30] = 64'hFFFF_FFFF_0000_0002;  mem[1]  = 64'hFFFF_FFFF_8000_0000;
    mem[31] = 64'h0001_0000_0000_0010;  mem[2]  = 64'h0001_0000_1000_0000;
    mem[0]  = 64'h0000_0000_FFFF_FFFF;  mem[3]  = 64'h0000_0000_0000_0003;
    mem[6]  = 64'h0002_0003_FFFF_0100;  mem[10] = 64'h0003_8000_FFFF_0100;
    mem[7]  = 64'h0000_FFFF_8000_0004;  mem[11] = 64'h0000_FFFF_0002_4000;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    check("reset_write_valid", 64'(vrf_write_valid), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_read_enable", 64'(vrf_read_enable), 64'd0);
    check("reset_state", 64'(debug_state), 64'd0);

    // vmul e64, two full beats
    push_exp(5'd12, 8'hFF, 64'h0000_0000_0000_000F);
    push_exp(5'd13, 8'hFF, 64'h0000_0003_0000_0000);
    issue_only(2'b00, 2'b11, 8'd2, 5'd4, 5'd8, 5'd12);
    wait_done("vmul_e64_latency", 9);

    // vmulh e8, partial second beat
    push_exp(5'd24, 8'hFF, 64'h00FF_0100_01FF_00FF);
    push_exp(5'd25, 8'h07, 64'h0000_0000_00FE_3FFF);
    issue_only(2'b01, 2'b00, 8'd11, 5'd16, 5'd20, 5'd24);
    wait_done("vmulh_e8_latency", 9);

    // vmulhu e32, register wrap, beat 0 write stalled five cycles
    push_exp(5'd31, 8'hFF, 64'hFFFF_FFFE_0000_0001);
    push_exp(5'd0,  8'hFF, 64'h0000_0001_0000_0001);
    push_exp(5'd1,  8'h0F, 64'h0000_0000_0000_0002);
    stall_left = 5;
    issue_only(2'b10, 2'b10, 8'd5, 5'd30, 5'd1, 5'd31);
    wait_done("vmulhu_stall_latency", 18);

    // vl = 0 retires without touching the VRF
    r0 = rd_seen;
    w0 = wr_seen;
    issue_only(2'b00, 2'b00, 8'd0, 5'd1, 5'd2, 5'd3);
    wait_done("vl0_latency", 1);
    check("vl0_no_reads", 64'(rd_seen - r0), 64'd0);
    check("vl0_no_writes", 64'(wr_seen - w0), 64'd0);

    // vmul e16 with a second issue offered while busy
    push_exp(5'd14, 8'hFF, 64'h0006_8000_0001_0000);
    issue_only(2'b00, 2'b01, 8'd4, 5'd6, 5'd10, 5'd14);
    issue_valid = 1'b1;
    issue_vl = 8'd0;
    issue_vd = 5'd20;
    check("busy_ready_low_0", 64'(issue_ready), 64'd0);
    @(negedge clock);
    check("busy_ready_low_1", 64'(issue_ready), 64'd0);
    @(negedge clock);
    issue_valid = 1'b0;
    wait_done("busy_latency", 5);

    // vmulhsu e16, three elements -> 6-byte strobe
    push_exp(5'd15, 8'h3F, 64'h0000_FFFF_FFFF_0001);
    issue_only(2'b11, 2'b01, 8'd3, 5'd7, 5'd11, 5'd15);
    wait_done("vmulhsu_tail_latency", 5);

`ifdef VMUL_SCALAR_EN
    push_exp(5'd18, 8'hFF, 64'h0000_FFFF_FFFE_0000);
    sc_valid = 1'b1;
    sc_operand = 64'h0000_0000_0000_0003;
    issue_only(2'b11, 2'b01, 8'd4, 5'd7, 5'd9, 5'd18);
    sc_valid = 1'b0;
    for (int k = 0; k < 10 && debug_state != 3'd3; k++) @(negedge clock);
    check("scalar_state_capture", 64'(debug_state), 64'd3);
    check("scalar_mul_vs1", mul_vs1, 64'h0003_0003_0003_0003);
    wait_done("scalar_latency", 5);
`endif

    // reset in the middle of a beat drops the instruction
    d0 = done_seen;
    w0 = wr_seen;
    issue_only(2'b00, 2'b11, 8'd8, 5'd0, 5'd1, 5'd2);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset_state", 64'(debug_state), 64'd0);
    check("midreset_issue_ready", 64'(issue_ready), 64'd1);
    check("midreset_write_valid", 64'(vrf_write_valid), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    check("midreset_no_done", 64'(done_seen - d0), 64'd0);
    check("midreset_no_writes", 64'(wr_seen - w0), 64'd0);
    check("midreset_idle", 64'(debug_state), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
